counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Sequencing controller for the team's free-running 4-bit up-counter datapath, turning it into a programmable interval timer. Latches a terminal value, sequences the count through run/hold/done phases, and emits a one-cycle terminal-count tick. Supports one-shot and auto-reload modes. Sits between software/control logic and any consumer of a periodic strobe.

Parameters:
WIDTH, 4, bit width of count and period

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch a count sequence (level-sampled each edge)
stop  input  1  abort sequence, return to IDLE
pause  input  1  freeze count while high (RUN/HOLD only)
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled with start
period  input  WIDTH  terminal count value, sampled with start
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN or HOLD
paused  output  1  high in HOLD
tick  output  1  one-cycle pulse on terminal count (registered)
done  output  1  high in DONE (one-shot complete)

Behaviour:
- Single clock domain; reset is synchronous and active-high: only acts on rising clk edge.
- Reset values: state=IDLE, count=0, period_q=0, reload_q=0, busy=0, paused=0, tick=0, done=0.
- All outputs registered; busy/paused/done decode directly from state register.
- Per-edge priority: reset > stop > start > pause > count advance.
- States: IDLE, RUN, HOLD, DONE.
- IDLE: start=1 and period!=0 -> period_q<=period, reload_q<=auto_reload, count<=0, ->RUN. start with period==0 ignored, stay IDLE. pause ignored.
- RUN: count!=period_q -> count<=count+1. count==period_q -> tick<=1; reload_q=1: count<=0, stay RUN; reload_q=0: count holds period_q, ->DONE. pause=1 (without terminal condition) -> HOLD, count unchanged. start ignored.
- Terminal condition beats pause on the same edge: tick fires, transition per mode; pause takes effect next edge if still high.
- HOLD: count frozen, tick=0; pause=0 -> RUN (counting resumes on following edge). start ignored.
- DONE: count holds period_q; start (period!=0) relatches and -> RUN with count<=0; start with period==0 -> stay DONE.
- stop=1 in any state -> IDLE, count<=0, tick<=0 (clears a pending tick).
- tick is high for exactly one cycle per terminal event; low otherwise.
- Timing: start at edge N -> RUN, count=0 after N; count=k after edge N+k; tick high after edge N+P+1. Periodic interval = P+1 cycles; tick coincident with count=0 (reload) or done=1 (one-shot).
- Arithmetic: count never exceeds period_q, so no wrap; period=2^WIDTH-1 valid.
- period/auto_reload changes mid-sequence have no effect until next start.
- reset mid-sequence: all state to reset values on that edge, regardless of other inputs.

Test Plan:
- Reset, then start=1 one cycle with period=5, auto_reload=0 -> count 0,1,2,3,4,5; tick one cycle with done=1 at count=5; busy low; count holds 5.
- period=3, auto_reload=1, start pulse -> count 0,1,2,3,0,1,...; tick every 4 cycles, aligned with count=0; done never high.
- period=9 one-shot, pause high 3 cycles at count=4 -> paused=1, count stays 4 for 3 cycles, resumes 5..9, tick at total of 10 RUN edges.
- period=6 periodic, stop asserted at count=2 -> next edge state IDLE, count=0, busy=0, tick=0; start with period=0 afterwards -> stays IDLE.
- start held high continuously with period=2 one-shot, stop/start in DONE -> start ignored in RUN; in DONE restarts from 0 next edge; period changed to 7 mid-RUN has no effect.
- reset asserted at count=3 together with start=1 and stop=1 -> all outputs return to 0, IDLE; deassert reset -> start launches normally.

Source files
------------

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//   Sequencing controller that turns a WIDTH-bit up-counter into a
//   programmable interval timer. It latches a terminal value on start, steps
//   through RUN/HOLD/DONE, and emits a one-cycle terminal-count tick. It
//   supports one-shot and auto-reload (periodic) modes.
//
// Ports
//   i_clk          system clock, all state updates on the rising edge
//   i_reset        synchronous, active-high reset
//   i_start        launch a count sequence (sampled every edge)
//   i_stop         abort the sequence and return to IDLE
//   i_pause        freeze the count while high (RUN/HOLD only)
//   i_auto_reload  1 = periodic, 0 = one-shot; sampled together with start
//   i_period       terminal count value; sampled together with start
//   o_count        current count value (registered)
//   o_busy         high in RUN or HOLD
//   o_paused       high in HOLD
//   o_tick         one-cycle pulse on terminal count (registered)
//   o_done         high in DONE (one-shot complete)
// ---------------------------------------------------------------------------
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_auto_reload,
    input  logic [WIDTH-1:0] i_period,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_paused,
    output logic             o_tick,
    output logic             o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period_q;
    logic             r_reload_q;
    logic             r_tick;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_period_nxt;
    logic             w_reload_nxt;
    logic             w_tick_nxt;
    logic             w_launch;
    logic             w_terminal;

    // A start with a zero period is meaningless and is dropped.
    assign w_launch   = i_start && (i_period != '0);
    assign w_terminal = (r_count == r_period_q);

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_period_nxt = r_period_q;
        w_reload_nxt = r_reload_q;
        w_tick_nxt   = 1'b0;

        if (i_stop) begin
            // Abort wins over everything except reset and drops any pending tick.
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        w_period_nxt = i_period;
                        w_reload_nxt = i_auto_reload;
                        w_count_nxt  = '0;
                        w_state_nxt  = S_RUN;
                    end
                end
                S_RUN: begin
                    // Terminal count takes precedence over pause on the same edge.
                    if (w_terminal) begin
                        w_tick_nxt = 1'b1;
                        if (r_reload_q) begin
                            w_count_nxt = '0;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else if (i_pause) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_count_nxt = WIDTH'(r_count + 1'b1);
                    end
                end
                S_HOLD: begin
                    if (!i_pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_period_q <= '0;
            r_reload_q <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_period_q <= w_period_nxt;
            r_reload_q <= w_reload_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign o_count  = r_count;
    assign o_tick   = r_tick;
    assign o_busy   = (r_state == S_RUN) || (r_state == S_HOLD);
    assign o_paused = (r_state == S_HOLD);
    assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
//   Directed-vector bench for counter_ctrl (WIDTH = 4). Inputs are driven
//   1 time unit after each rising edge; outputs are checked at that point,
//   reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             tick;
    logic             done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_stop        (stop),
        .i_pause       (pause),
        .i_auto_reload (auto_reload),
        .i_period      (period),
        .o_count       (count),
        .o_busy        (busy),
        .o_paused      (paused),
        .o_tick        (tick),
        .o_done        (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Output vector packed as {count, busy, paused, tick, done}.
    task automatic expect_out(input string tag, input int c, input bit b, input bit p,
                              input bit t, input bit d);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = {20'd0, count, busy, paused, tick, done};
        exp = {20'd0, 4'(c), b, p, t, d};
        check_val(tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        auto_reload = 1'b0; period = '0;
        cyc();
        cyc();
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // One-shot, period 5
        start = 1'b1; period = 4'd5; auto_reload = 1'b0;
        cyc();
        expect_out("os5_start", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            expect_out($sformatf("os5_cnt%0d", k), k, 1, 0, 0, 0);
        end
        cyc();
        expect_out("os5_tick", 5, 0, 0, 1, 1);
        cyc();
        expect_out("os5_hold1", 5, 0, 0, 0, 1);
        cyc();
        expect_out("os5_hold2", 5, 0, 0, 0, 1);

        // Periodic, period 3, launched from DONE
        start = 1'b1; period = 4'd3; auto_reload = 1'b1;
        cyc();
        expect_out("per3_start", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            expect_out($sformatf("per3_%0d", i), i % 4, 1, 0, (i % 4) == 0, 0);
        end
        stop = 1'b1;
        cyc();
        expect_out("per3_stop", 0, 0, 0, 0, 0);
        stop = 1'b0;

        // One-shot, period 9, pause for 3 cycles at count 4
        start = 1'b1; period = 4'd9; auto_reload = 1'b0;
        cyc();
        expect_out("p9_start", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) cyc();
        expect_out("p9_cnt4", 4, 1, 0, 0, 0);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_out($sformatf("p9_hold%0d", k), 4, 1, 1, 0, 0);
        end
        pause = 1'b0;
        cyc();
        expect_out("p9_resume", 4, 1, 0, 0, 0);
        for (int k = 5; k <= 9; k++) begin
            cyc();
            expect_out($sformatf("p9_cnt%0d", k), k, 1, 0, 0, 0);
        end
        // Pause raised on the terminal edge: terminal count wins
        pause = 1'b1;
        cyc();
        expect_out("p9_tick_vs_pause", 9, 0, 0, 1, 1);
        pause = 1'b0;

        // Periodic, period 6, stop at count 2, then zero-period start ignored
        start = 1'b1; period = 4'd6; auto_reload = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        expect_out("s6_cnt2", 2, 1, 0, 0, 0);
        stop = 1'b1;
        cyc();
        expect_out("s6_stop", 0, 0, 0, 0, 0);
        stop = 1'b0; start = 1'b1; period = 4'd0;
        cyc();
        expect_out("s6_zero_start", 0, 0, 0, 0, 0);
        start = 1'b0;

        // Stop on the terminal edge suppresses the tick
        start = 1'b1; period = 4'd1; auto_reload = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        expect_out("s1_cnt1", 1, 1, 0, 0, 0);
        stop = 1'b1;
        cyc();
        expect_out("s1_stop_tick", 0, 0, 0, 0, 0);
        stop = 1'b0;

        // Start held high, period 2 one-shot; mid-run period change ignored
        start = 1'b1; period = 4'd2; auto_reload = 1'b0;
        cyc();
        expect_out("h2_start", 0, 1, 0, 0, 0);
        cyc();
        expect_out("h2_cnt1", 1, 1, 0, 0, 0);
        period = 4'd7;
        cyc();
        expect_out("h2_cnt2", 2, 1, 0, 0, 0);
        cyc();
        expect_out("h2_tick", 2, 0, 0, 1, 1);
        period = 4'd0;
        cyc();
        expect_out("h2_done_zero", 2, 0, 0, 0, 1);
        period = 4'd7;
        cyc();
        expect_out("h2_restart", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 3; k++) cyc();
        expect_out("h2_cnt3", 3, 1, 0, 0, 0);

        // Reset mid-run with start and stop also high
        reset = 1'b1; start = 1'b1; stop = 1'b1;
        cyc();
        expect_out("rst_mid", 0, 0, 0, 0, 0);
        reset = 1'b0; stop = 1'b0; start = 1'b1; period = 4'd2; auto_reload = 1'b0;
        cyc();
        expect_out("rst_relaunch", 0, 1, 0, 0, 0);
        start = 1'b0;
        cyc();
        cyc();
        expect_out("rst_cnt2", 2, 1, 0, 0, 0);
        cyc();
        expect_out("rst_tick", 2, 0, 0, 1, 1);

        // Full-scale period 15, periodic
        start = 1'b1; period = 4'd15; auto_reload = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            cyc();
            expect_out($sformatf("p15_%0d", i), i % 16, 1, 0, (i % 16) == 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
